hsi_burst_mover: RTL and testbench



---
 rtl/hsi_burst_mover.sv | 185 ++++++++++++++++++
 tb/tb_hsi_burst_mover.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_burst_mover.sv
// AXI4 read-to-stream mover: splits a {tag,length,address} command into INCR
// bursts (MAX_BURST / 4 KiB limited) and forwards the read data on AXI4-Stream.
module hsi_burst_mover #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_BURST       = 256,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [LEN_WIDTH+ADDR_WIDTH:0]   cmd_tdata,
  input  logic                            cmd_tvalid,
  output logic                            cmd_tready,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            busy,
  output logic                            rd_err
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2  = $clog2(BYTES);
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PAGE_BYTES = 4096;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  // Beats in the next burst: bounded by remaining length, MAX_BURST and the 4 KiB page.
  function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                             input logic [LEN_WIDTH-1:0] rem);
    logic [31:0] room;
    logic [31:0] rem32;
    logic [31:0] n;
    room  = (32'(PAGE_BYTES) - 32'(page_off)) >> SIZE_LOG2;
    rem32 = 32'(rem);
    n     = 32'(MAX_BURST);
    if (room < n)  n = room;
    if (rem32 < n) n = rem32;
    return 9'(n);
  endfunction

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]   rem_ar_q, rem_ar_d;
  logic [LEN_WIDTH-1:0]   rem_r_q, rem_r_d;
  logic                   tag_q, tag_d;
  logic [OUT_W-1:0]       out_q, out_d;
  logic                   arvalid_q, arvalid_d;
  logic [7:0]             arlen_q, arlen_d;
  logic                   cmd_tready_q;
  logic                   busy_q;
  logic                   rd_err_q, rd_err_d;

  logic                   cmd_tag;
  logic [LEN_WIDTH-1:0]   cmd_len;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic                   cmd_hs, ar_hs, r_hs, r_last_hs;
  logic [31:0]            issued_beats;
  logic [8:0]             next_beats;

  assign {cmd_tag, cmd_len, cmd_addr} = cmd_tdata;

  assign cmd_hs    = cmd_tvalid & cmd_tready_q;
  assign ar_hs     = arvalid_q & m_axi_arready;
  assign r_hs      = m_axi_rvalid & m_axis_tready;
  assign r_last_hs = r_hs & m_axi_rlast;

  // Next-state, counters and AR payload for the following cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_ar_d     = rem_ar_q;
    rem_r_d      = rem_r_q;
    tag_d        = tag_q;
    out_d        = out_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_d    = 1'b0;
    rd_err_d     = rd_err_q | (r_hs & (m_axi_rresp != 2'b00));
    issued_beats = 32'(arlen_q) + 32'd1;
    next_beats   = 9'd0;

    if (ar_hs && !r_last_hs) begin
      out_d = out_q + OUT_W'(1);
    end else if (!ar_hs && r_last_hs) begin
      out_d = out_q - OUT_W'(1);
    end

    if (r_hs && (rem_r_q != '0)) begin
      rem_r_d = rem_r_q - LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          addr_d   = cmd_addr & ADDR_MASK;
          rem_ar_d = cmd_len;
          rem_r_d  = cmd_len;
          tag_d    = cmd_tag;
          if (cmd_len != '0) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ar_hs) begin
          addr_d   = addr_q + ADDR_WIDTH'(issued_beats << SIZE_LOG2);
          rem_ar_d = rem_ar_q - LEN_WIDTH'(issued_beats);
          if (rem_ar_d == '0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_hs && (rem_r_q == LEN_WIDTH'(1))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The AR payload only changes after a handshake, so it is stable while arvalid waits.
    if (state_d == S_ISSUE) begin
      next_beats = burst_beats(addr_d[11:0], rem_ar_d);
      araddr_d   = addr_d;
      arlen_d    = 8'(next_beats - 9'd1);
      arvalid_d  = (out_d < OUT_W'(MAX_OUTSTANDING));
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      araddr_q     <= '0;
      rem_ar_q     <= '0;
      rem_r_q      <= '0;
      tag_q        <= 1'b0;
      out_q        <= '0;
      arvalid_q    <= 1'b0;
      arlen_q      <= 8'd0;
      cmd_tready_q <= 1'b0;
      busy_q       <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      araddr_q     <= araddr_d;
      rem_ar_q     <= rem_ar_d;
      rem_r_q      <= rem_r_d;
      tag_q        <= tag_d;
      out_q        <= out_d;
      arvalid_q    <= arvalid_d;
      arlen_q      <= arlen_d;
      cmd_tready_q <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
      rd_err_q     <= rd_err_d;
    end
  end

  assign cmd_tready    = cmd_tready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign busy          = busy_q;
  assign rd_err        = rd_err_q;

  // R channel is a zero-latency pass-through onto the stream.
  assign m_axi_rready  = m_axis_tready;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tvalid = m_axi_rvalid;
  assign m_axis_tlast  = m_axi_rvalid & m_axi_rlast & tag_q & (rem_r_q == LEN_WIDTH'(1));

endmodule

// File: tb/tb_hsi_burst_mover.sv
// Directed bench for hsi_burst_mover: instance A uses default parameters,
// instance B uses MAX_BURST=4 / MAX_OUTSTANDING=2; one slave model serves the selected one.
module tb_hsi_burst_mover;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic        sel;
  logic [48:0] cmd_tdata;
  logic        cmd_tvalid, arready, rvalid, rlast, tready;
  logic [1:0]  rresp;
  logic [63:0] rdata;

  logic        a_cmd_tready, a_arvalid, a_rready, a_tlast, a_tvalid, a_busy, a_rd_err;
  logic [31:0] a_araddr;
  logic [7:0]  a_arlen;
  logic [2:0]  a_arsize;
  logic [1:0]  a_arburst;
  logic [63:0] a_tdata;
  logic        b_cmd_tready, b_arvalid, b_rready, b_tlast, b_tvalid, b_busy, b_rd_err;
  logic [31:0] b_araddr;
  logic [7:0]  b_arlen;
  logic [2:0]  b_arsize;
  logic [1:0]  b_arburst;
  logic [63:0] b_tdata;

  hsi_burst_mover u_a (
    .clk(clk), .aresetn(aresetn),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid & ~sel), .cmd_tready(a_cmd_tready),
    .m_axi_araddr(a_araddr), .m_axi_arlen(a_arlen), .m_axi_arsize(a_arsize),
    .m_axi_arburst(a_arburst), .m_axi_arvalid(a_arvalid), .m_axi_arready(arready & ~sel),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid & ~sel), .m_axi_rready(a_rready),
    .m_axis_tdata(a_tdata), .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(tready & ~sel), .busy(a_busy), .rd_err(a_rd_err)
  );

  hsi_burst_mover #(.MAX_BURST(4), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .aresetn(aresetn),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid & sel), .cmd_tready(b_cmd_tready),
    .m_axi_araddr(b_araddr), .m_axi_arlen(b_arlen), .m_axi_arsize(b_arsize),
    .m_axi_arburst(b_arburst), .m_axi_arvalid(b_arvalid), .m_axi_arready(arready & sel),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid & sel), .m_axi_rready(b_rready),
    .m_axis_tdata(b_tdata), .m_axis_tlast(b_tlast), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(tready & sel), .busy(b_busy), .rd_err(b_rd_err)
  );

  wire        o_cmd_tready = sel ? b_cmd_tready : a_cmd_tready;
  wire        o_arvalid    = sel ? b_arvalid    : a_arvalid;
  wire [31:0] o_araddr     = sel ? b_araddr     : a_araddr;
  wire [7:0]  o_arlen      = sel ? b_arlen      : a_arlen;
  wire [2:0]  o_arsize     = sel ? b_arsize     : a_arsize;
  wire [1:0]  o_arburst    = sel ? b_arburst    : a_arburst;
  wire        o_rready     = sel ? b_rready     : a_rready;
  wire [63:0] o_tdata      = sel ? b_tdata      : a_tdata;
  wire        o_tlast      = sel ? b_tlast      : a_tlast;
  wire        o_tvalid     = sel ? b_tvalid     : a_tvalid;
  wire        o_busy       = sel ? b_busy       : a_busy;
  wire        o_rd_err     = sel ? b_rd_err     : a_rd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        cmd_pending;
  logic [48:0] cmd_next;
  int          cmd_acc_cyc, first_arv_cyc;
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [2:0]  ar_size_q[$];
  logic [1:0]  ar_burst_q[$];
  int          ar_cyc_q[$];
  logic [31:0] pend_addr[$];
  int          pend_len[$];
  int          beat_idx, r_cnt, err_beat, max_pend, rr_mis, ars_before_rlast;
  logic        r_hold, tready_toggle, seen_rlast;
  logic [63:0] bt_data[$];
  logic        bt_last[$];
  int          bt_cyc[$];

  // One clock: drive at negedge, observe the handshakes that the next posedge will take.
  task automatic step();
    @(negedge clk);
    cmd_tvalid = cmd_pending;
    if (cmd_pending) cmd_tdata = cmd_next;
    arready = 1'b1;
    if (!r_hold && pend_addr.size() > 0) begin
      rvalid = 1'b1;
      rdata  = {32'hFACE_0000, pend_addr[0] + 32'(beat_idx * 8)};
      rlast  = (beat_idx == pend_len[0] - 1);
      rresp  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      rlast  = 1'b0;
      rresp  = 2'b00;
    end
    tready = tready_toggle ? ~tready : 1'b1;
    #1;
    if (o_rready !== tready) rr_mis++;
    if (cmd_tvalid && o_cmd_tready) begin
      cmd_pending = 1'b0;
      cmd_acc_cyc = cyc;
    end
    if (o_arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
    if (o_arvalid && arready) begin
      ar_addr_q.push_back(o_araddr);
      ar_len_q.push_back(o_arlen);
      ar_size_q.push_back(o_arsize);
      ar_burst_q.push_back(o_arburst);
      ar_cyc_q.push_back(cyc);
      pend_addr.push_back(o_araddr);
      pend_len.push_back(int'(o_arlen) + 1);
    end
    if (o_tvalid && tready) begin
      bt_data.push_back(o_tdata);
      bt_last.push_back(o_tlast);
      bt_cyc.push_back(cyc);
    end
    if (rvalid && o_rready) begin
      r_cnt++;
      if (rlast) begin
        if (!seen_rlast) begin
          seen_rlast       = 1'b1;
          ars_before_rlast = ar_addr_q.size();
        end
        void'(pend_addr.pop_front());
        void'(pend_len.pop_front());
        beat_idx = 0;
      end else begin
        beat_idx++;
      end
    end
    if (pend_addr.size() > max_pend) max_pend = pend_addr.size();
    cyc++;
  endtask

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); ar_size_q.delete(); ar_burst_q.delete();
    ar_cyc_q.delete(); pend_addr.delete(); pend_len.delete();
    bt_data.delete(); bt_last.delete(); bt_cyc.delete();
    beat_idx = 0; r_cnt = 0; err_beat = -1; max_pend = 0; rr_mis = 0;
    ars_before_rlast = 0; seen_rlast = 1'b0; cmd_acc_cyc = -1; first_arv_cyc = -1;
  endtask

  task automatic send(input logic [31:0] addr, input logic [15:0] len, input logic tag);
    cmd_next    = {tag, len, addr};
    cmd_pending = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && bt_data.size() < n; i++) step();
  endtask

  task automatic wait_accept(input int budget);
    for (int i = 0; i < budget && cmd_pending; i++) step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({o_arvalid, o_busy, o_rd_err, o_cmd_tready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_flags got arvalid/busy/rd_err/cmd_tready=%b want 0000",
               {o_arvalid, o_busy, o_rd_err, o_cmd_tready});
    end
    n_checks++;
    if (o_araddr !== 32'h0 || o_arlen !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_ar got araddr=%h arlen=%h want 0/0", o_araddr, o_arlen);
    end
    aresetn = 1'b1;
    step();
    n_checks++;
    if (o_cmd_tready !== 1'b1 || o_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release got cmd_tready=%b arvalid=%b want 1/0", o_cmd_tready, o_arvalid);
    end
  endtask

  task automatic test_single_burst();
    sel = 1'b0;
    clear_logs();
    send(32'h0010_0000, 16'd2, 1'b1);
    wait_beats(2, 100);
    n_checks++;
    if (bt_data.size() !== 2) begin
      n_fail++;
      $display("FAIL t1_beats got %0d want 2", bt_data.size());
    end
    n_checks++;
    if (first_arv_cyc !== cmd_acc_cyc + 1) begin
      n_fail++;
      $display("FAIL t1_ar_latency got cycle %0d want %0d", first_arv_cyc, cmd_acc_cyc + 1);
    end
    n_checks++;
    if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== 32'h0010_0000 || ar_len_q[0] !== 8'd1 ||
        ar_size_q[0] !== 3'd3 || ar_burst_q[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL t1_ar got n=%0d addr=%h len=%0d size=%0d burst=%b want 1 00100000 1 3 01",
               ar_addr_q.size(), ar_addr_q[0], ar_len_q[0], ar_size_q[0], ar_burst_q[0]);
    end
    n_checks++;
    if (bt_data[0] !== 64'hFACE0000_00100000 || bt_data[1] !== 64'hFACE0000_00100008 ||
        bt_last[0] !== 1'b0 || bt_last[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_data got %h/%b %h/%b want FACE000000100000/0 FACE000000100008/1",
               bt_data[0], bt_last[0], bt_data[1], bt_last[1]);
    end
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_busy_last_beat got %b want 1", o_busy);
    end
    step();
    n_checks++;
    if (o_busy !== 1'b0 || o_cmd_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_done got busy=%b cmd_tready=%b want 0/1", o_busy, o_cmd_tready);
    end
  endtask

  task automatic test_4k_split();
    int mis = 0;
    int nlast = 0;
    sel = 1'b0;
    clear_logs();
    send(32'h0010_0FF1, 16'd12, 1'b1);
    wait_beats(12, 200);
    repeat (3) step();
    n_checks++;
    if (ar_addr_q.size() !== 2 || ar_addr_q[0] !== 32'h0010_0FF0 || ar_len_q[0] !== 8'd1 ||
        ar_addr_q[1] !== 32'h0010_1000 || ar_len_q[1] !== 8'd9) begin
      n_fail++;
      $display("FAIL t2_ars got n=%0d %h/%0d %h/%0d want 2 00100ff0/1 00101000/9",
               ar_addr_q.size(), ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
    end
    for (int i = 0; i < 12 && i < bt_data.size(); i++) begin
      if (bt_data[i] !== {32'hFACE_0000, 32'h0010_0FF0 + 32'(i * 8)}) mis++;
      if (bt_last[i]) nlast++;
    end
    n_checks++;
    if (bt_data.size() !== 12 || mis !== 0) begin
      n_fail++;
      $display("FAIL t2_data got beats=%0d mismatches=%0d want 12/0", bt_data.size(), mis);
    end
    n_checks++;
    if (nlast !== 1 || bt_last[11] !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_tlast got count=%0d last=%b want 1/1", nlast, bt_last[11]);
    end
  endtask

  task automatic test_max_burst_split();
    int mis = 0;
    int nlast = 0;
    sel = 1'b0;
    clear_logs();
    send(32'h0020_0000, 16'd300, 1'b0);
    wait_beats(300, 1000);
    repeat (3) step();
    n_checks++;
    if (ar_addr_q.size() !== 2 || ar_addr_q[0] !== 32'h0020_0000 || ar_len_q[0] !== 8'd255 ||
        ar_addr_q[1] !== 32'h0020_0800 || ar_len_q[1] !== 8'd43) begin
      n_fail++;
      $display("FAIL t3_ars got n=%0d %h/%0d %h/%0d want 2 00200000/255 00200800/43",
               ar_addr_q.size(), ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
    end
    for (int i = 0; i < 300 && i < bt_data.size(); i++) begin
      if (bt_data[i] !== {32'hFACE_0000, 32'h0020_0000 + 32'(i * 8)}) mis++;
      if (bt_last[i]) nlast++;
    end
    n_checks++;
    if (bt_data.size() !== 300 || mis !== 0 || nlast !== 0) begin
      n_fail++;
      $display("FAIL t3_data got beats=%0d mismatches=%0d tlasts=%0d want 300/0/0",
               bt_data.size(), mis, nlast);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    clear_logs();
    send(32'h0070_0000, 16'd2, 1'b1);
    wait_accept(20);
    send(32'h0070_0040, 16'd2, 1'b1);
    wait_beats(4, 100);
    repeat (3) step();
    n_checks++;
    if (bt_data.size() !== 4 || cmd_acc_cyc !== bt_cyc[1] + 1) begin
      n_fail++;
      $display("FAIL b2b_accept got beats=%0d accept cycle=%0d want 4 beats, cycle %0d",
               bt_data.size(), cmd_acc_cyc, bt_cyc[1] + 1);
    end
    n_checks++;
    if (bt_data[2] !== 64'hFACE0000_00700040 || bt_data[3] !== 64'hFACE0000_00700048 ||
        bt_last[1] !== 1'b1 || bt_last[3] !== 1'b1 || bt_last[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_data got %h %h last=%b%b%b want FACE000000700040 FACE000000700048 last=101",
               bt_data[2], bt_data[3], bt_last[1], bt_last[2], bt_last[3]);
    end
  endtask

  task automatic test_outstanding();
    int mis = 0;
    int nlast = 0;
    sel = 1'b1;
    clear_logs();
    r_hold = 1'b1;
    send(32'h0030_0000, 16'd16, 1'b1);
    repeat (20) step();
    n_checks++;
    if (ar_addr_q.size() !== 2 || ar_addr_q[1] !== 32'h0030_0020 || ar_len_q[0] !== 8'd3 ||
        ar_cyc_q[1] !== ar_cyc_q[0] + 1) begin
      n_fail++;
      $display("FAIL t4_held_ars got n=%0d addr1=%h len0=%0d cyc %0d,%0d want 2 00300020 3 consecutive",
               ar_addr_q.size(), ar_addr_q[1], ar_len_q[0], ar_cyc_q[0], ar_cyc_q[1]);
    end
    r_hold = 1'b0;
    tready_toggle = 1'b1;
    wait_beats(16, 400);
    repeat (6) step();
    tready_toggle = 1'b0;
    n_checks++;
    if (ar_addr_q.size() !== 4 || ars_before_rlast !== 2 || max_pend !== 2) begin
      n_fail++;
      $display("FAIL t4_limit got ars=%0d before_rlast=%0d max_out=%0d want 4/2/2",
               ar_addr_q.size(), ars_before_rlast, max_pend);
    end
    for (int i = 0; i < 16 && i < bt_data.size(); i++) begin
      if (bt_data[i] !== {32'hFACE_0000, 32'h0030_0000 + 32'(i * 8)}) mis++;
      if (bt_last[i]) nlast++;
    end
    n_checks++;
    if (bt_data.size() !== 16 || mis !== 0 || nlast !== 1 || bt_last[15] !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_data got beats=%0d mismatches=%0d tlasts=%0d want 16/0/1",
               bt_data.size(), mis, nlast);
    end
    n_checks++;
    if (rr_mis !== 0) begin
      n_fail++;
      $display("FAIL t4_rready got %0d cycles rready!=tready want 0", rr_mis);
    end
  endtask

  task automatic test_error_and_zero();
    int mis = 0;
    sel = 1'b0;
    clear_logs();
    n_checks++;
    if (o_rd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_err_pre got %b want 0", o_rd_err);
    end
    err_beat = 2;
    send(32'h0040_0000, 16'd5, 1'b1);
    wait_beats(5, 100);
    step();
    for (int i = 0; i < 5 && i < bt_data.size(); i++)
      if (bt_data[i] !== {32'hFACE_0000, 32'h0040_0000 + 32'(i * 8)}) mis++;
    n_checks++;
    if (o_rd_err !== 1'b1 || bt_data.size() !== 5 || mis !== 0 || bt_last[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_err got rd_err=%b beats=%0d mismatches=%0d want 1/5/0",
               o_rd_err, bt_data.size(), mis);
    end
    clear_logs();
    send(32'h0040_0100, 16'd0, 1'b1);
    wait_accept(10);
    step();
    n_checks++;
    if (cmd_acc_cyc < 0 || o_cmd_tready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_zero got accepted_cycle=%0d cmd_tready=%b busy=%b want >=0/1/0",
               cmd_acc_cyc, o_cmd_tready, o_busy);
    end
    repeat (5) step();
    n_checks++;
    if (ar_addr_q.size() !== 0 || bt_data.size() !== 0 || o_rd_err !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_zero_quiet got ars=%0d beats=%0d rd_err=%b want 0/0/1",
               ar_addr_q.size(), bt_data.size(), o_rd_err);
    end
  endtask

  task automatic test_reset_mid();
    int mis = 0;
    sel = 1'b0;
    clear_logs();
    send(32'h0050_0000, 16'd12, 1'b1);
    wait_beats(4, 100);
    aresetn = 1'b0;
    clear_logs();
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if ({o_arvalid, o_busy, o_rd_err, o_cmd_tready} !== 4'b0000) begin
        n_fail++;
        $display("FAIL t6_in_reset%0d got arvalid/busy/rd_err/cmd_tready=%b want 0000",
                 k, {o_arvalid, o_busy, o_rd_err, o_cmd_tready});
      end
    end
    aresetn = 1'b1;
    step();
    clear_logs();
    send(32'h0060_0000, 16'd2, 1'b1);
    wait_beats(2, 100);
    step();
    for (int i = 0; i < 2 && i < bt_data.size(); i++)
      if (bt_data[i] !== {32'hFACE_0000, 32'h0060_0000 + 32'(i * 8)}) mis++;
    n_checks++;
    if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== 32'h0060_0000 || bt_data.size() !== 2 ||
        mis !== 0 || bt_last[1] !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_after got ars=%0d addr=%h beats=%0d mismatches=%0d busy=%b want 1 00600000 2 0 0",
               ar_addr_q.size(), ar_addr_q[0], bt_data.size(), mis, o_busy);
    end
  endtask

  initial begin
    sel = 1'b0; aresetn = 1'b0; cmd_tdata = '0; cmd_tvalid = 1'b0; cmd_next = '0;
    cmd_pending = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    rdata = '0; tready = 1'b1; r_hold = 1'b0; tready_toggle = 1'b0;
    clear_logs();
    test_reset();
    test_single_burst();
    test_4k_split();
    test_max_burst_split();
    test_back_to_back();
    test_outstanding();
    test_error_and_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
